// File: rtl/mips_mem_pkg.sv
// Shared definitions for the core-side memory responders: loader FSM states,
// word geometry and the address alignment/range check.
package mips_mem_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} ld_state_e;

  localparam int BYTES_PER_WORD = 4;

  typedef struct packed {
    logic misaligned;
    logic out_of_range;
  } acc_chk_t;

  function automatic acc_chk_t check_access(input logic [31:0] addr, input int addr_w);
    acc_chk_t c;
    c.misaligned   = |addr[1:0];
    c.out_of_range = (addr >> (addr_w + 2)) != 32'd0;
    return c;
  endfunction

endpackage

// File: rtl/dmem_loader_fsm.sv
// Byte-serial preload engine: assembles big-endian bytes into words and
// emits one memory write per word through a single write port.
module dmem_loader_fsm
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_start_i,
  input  logic              ld_valid_i,
  input  logic [7:0]        ld_byte_i,
  input  logic              ld_last_i,
  output logic              ld_ready_o,
  output logic              busy_o,
  output logic [ADDR_W:0]   ld_words_o,
  output logic              ld_ovf_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [31:0]       wdata_o
);

  ld_state_e         state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [31:0]       shreg_q, shreg_d;
  logic              last_q, last_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic              ovf_q, ovf_d;
  logic [31:0]       acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      shreg_q <= '0;
      last_q  <= 1'b0;
      words_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      last_q  <= last_d;
      words_q <= words_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    last_d     = last_q;
    words_d    = words_q;
    ovf_d      = ovf_q;
    ld_ready_o = 1'b0;
    we_o       = 1'b0;
    acc        = {shreg_q[23:0], ld_byte_i};
    case (state_q)
      IDLE: begin
        if (ld_start_i) begin
          ptr_d   = '0;
          cnt_d   = '0;
          shreg_d = '0;
          last_d  = 1'b0;
          words_d = '0;
          ovf_d   = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        ld_ready_o = 1'b1;
        if (ld_valid_i) begin
          cnt_d = cnt_q + 3'd1;
          // A short final word is left-justified: shift out the missing low bytes.
          shreg_d = ld_last_i ? (acc << (5'd24 - {cnt_q[1:0], 3'b000})) : acc;
          if (ld_last_i || cnt_q == 3'(BYTES_PER_WORD - 1)) begin
            last_d  = ld_last_i;
            state_d = COMMIT;
          end
        end
      end
      COMMIT: begin
        we_o    = 1'b1;
        words_d = words_q + 1'b1;
        cnt_d   = '0;
        shreg_d = '0;
        if (last_q) begin
          state_d = IDLE;
        end else if (ptr_q == '1) begin
          ovf_d   = 1'b1;
          state_d = IDLE;
        end else begin
          ptr_d   = ptr_q + 1'b1;
          state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o     = (state_q != IDLE);
  assign ld_words_o = words_q;
  assign ld_ovf_o   = ovf_q;
  assign waddr_o    = ptr_q;
  assign wdata_o    = shreg_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target for the core: same-cycle word reads, edge-committed
// writes, access-error pulse, and a byte-serial preload port.
module dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  input  logic              data_wr,
  output logic [DATA_W-1:0] data_rdata,
  output logic              acc_err,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [7:0]        ld_byte,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              busy,
  output logic [ADDR_W:0]   ld_words,
  output logic              ld_ovf
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  acc_chk_t          chk;
  logic              core_we;
  logic              acc_err_q, acc_err_d;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_waddr;
  logic [31:0]       ld_wdata;
  logic [ADDR_W-1:0] word_idx;

  dmem_loader_fsm #(.ADDR_W(ADDR_W)) u_loader (
    .clk        (clk),
    .rst_n      (rst_n),
    .ld_start_i (ld_start),
    .ld_valid_i (ld_valid),
    .ld_byte_i  (ld_byte),
    .ld_last_i  (ld_last),
    .ld_ready_o (ld_ready),
    .busy_o     (busy),
    .ld_words_o (ld_words),
    .ld_ovf_o   (ld_ovf),
    .we_o       (ld_we),
    .waddr_o    (ld_waddr),
    .wdata_o    (ld_wdata)
  );

  assign chk       = check_access(data_addr, ADDR_W);
  assign word_idx  = data_addr[ADDR_W+1:2];
  // Core writes are blocked during preload, so the two write sources never collide.
  assign core_we   = data_wr & ~chk.misaligned & ~chk.out_of_range & ~busy;
  assign acc_err_d = chk.misaligned | (data_wr & (chk.out_of_range | busy));

  always_ff @(posedge clk) begin
    if (ld_we) begin
      mem[ld_waddr] <= ld_wdata;
    end else if (core_we) begin
      mem[word_idx] <= data_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_err_q <= 1'b0;
    end else begin
      acc_err_q <= acc_err_d;
    end
  end

  assign data_rdata = chk.out_of_range ? '0 : mem[word_idx];
  assign acc_err    = acc_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: preload, core access table, busy/reset
// corner cases, and overflow on a small-depth instance.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data_addr = '0, data_wdata = '0, data_rdata;
  logic        data_wr = 1'b0, acc_err;
  logic        ld_start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0;
  logic [7:0]  ld_byte = '0;
  logic        ld_ready, busy, ld_ovf;
  logic [8:0]  ld_words;

  logic [31:0] data_addr2 = '0, data_wdata2 = '0, data_rdata2;
  logic        data_wr2 = 1'b0, acc_err2, ld_start2 = 1'b0;
  logic        ld_ready2, busy2, ld_ovf2;
  logic [2:0]  ld_words2;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(8), .DATA_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_wr(data_wr), .data_rdata(data_rdata), .acc_err(acc_err),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_last(ld_last),
    .ld_ready(ld_ready), .busy(busy), .ld_words(ld_words), .ld_ovf(ld_ovf)
  );

  dmem_responder #(.ADDR_W(2), .DATA_W(32)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .data_addr(data_addr2), .data_wdata(data_wdata2),
    .data_wr(data_wr2), .data_rdata(data_rdata2), .acc_err(acc_err2),
    .ld_start(ld_start2), .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_last(ld_last),
    .ld_ready(ld_ready2), .busy(busy2), .ld_words(ld_words2), .ld_ovf(ld_ovf2)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic        chk_now;
    logic [31:0] rd_now;
    logic [31:0] rd_next;
    logic        err;
  } cvec_t;

  cvec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic start_load(input logic sel);
    @(negedge clk);
    if (sel) ld_start2 = 1'b1; else ld_start = 1'b1;
    @(posedge clk); #1;
    ld_start = 1'b0;
    ld_start2 = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last, input logic sel);
    int n = 0;
    ld_valid = 1'b1;
    ld_byte  = b;
    ld_last  = last;
    @(negedge clk);
    while (!(sel ? ld_ready2 : ld_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (!(sel ? ld_ready2 : ld_ready)) begin
      n_fail++;
      $display("FAIL ld_ready_timeout: got 0 expected 1 for byte %h", b);
    end
    @(posedge clk); #1;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] addr, input logic [31:0] exp);
    data_addr = addr;
    #1;
    chk(nm, data_rdata, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h8,   32'h01020304, 1'b1, 1'b0, 32'h0,        32'h01020304, 1'b0};
    vecs[1] = '{32'h8,   32'hCAFEF00D, 1'b1, 1'b1, 32'h01020304, 32'hCAFEF00D, 1'b0};
    vecs[2] = '{32'h6,   32'hDEADBEEF, 1'b1, 1'b1, 32'hAABB0000, 32'hAABB0000, 1'b1};
    vecs[3] = '{32'h400, 32'hDEADBEEF, 1'b1, 1'b1, 32'h0,        32'h0,        1'b1};
    vecs[4] = '{32'h4,   32'h0,        1'b0, 1'b1, 32'hAABB0000, 32'hAABB0000, 1'b0};
    vecs[5] = '{32'h0,   32'h0,        1'b0, 1'b1, 32'h11223344, 32'h11223344, 1'b0};
    vecs[6] = '{32'h7,   32'h0,        1'b0, 1'b1, 32'hAABB0000, 32'hAABB0000, 1'b1};
    vecs[7] = '{32'h401, 32'h0,        1'b0, 1'b1, 32'h0,        32'h0,        1'b1};
    vecs[8] = '{32'h404, 32'h0,        1'b0, 1'b1, 32'h0,        32'h0,        1'b0};
    vecs[9] = '{32'h8,   32'h0,        1'b0, 1'b1, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_acc_err", acc_err, 0);
    chk("rst_ld_words", ld_words, 0);
    chk("rst_ld_ovf", ld_ovf, 0);
    chk("rst_ld_ovf2", ld_ovf2, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 8-byte image, two full words
    start_load(0);
    send_byte(8'h12, 0, 0); send_byte(8'h34, 0, 0);
    send_byte(8'h56, 0, 0); send_byte(8'h78, 0, 0);
    send_byte(8'h9A, 0, 0); send_byte(8'hBC, 0, 0);
    send_byte(8'hDE, 0, 0); send_byte(8'hF0, 1, 0);
    @(negedge clk);
    chk("img1_busy_in_commit", busy, 1);
    @(negedge clk);
    chk("img1_busy_drop", busy, 0);
    chk("img1_ld_words", ld_words, 2);
    rd_chk("img1_mem0", 32'h0, 32'h12345678);
    rd_chk("img1_mem1", 32'h4, 32'h9ABCDEF0);

    // 6-byte image, short final word is zero-padded
    start_load(0);
    send_byte(8'h11, 0, 0); send_byte(8'h22, 0, 0);
    send_byte(8'h33, 0, 0); send_byte(8'h44, 0, 0);
    send_byte(8'hAA, 0, 0); send_byte(8'hBB, 1, 0);
    @(negedge clk);
    @(negedge clk);
    chk("img2_busy", busy, 0);
    chk("img2_ld_words", ld_words, 2);
    rd_chk("img2_mem0", 32'h0, 32'h11223344);
    rd_chk("img2_mem1", 32'h4, 32'hAABB0000);

    // core access table
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      data_addr  = vecs[i].addr;
      data_wdata = vecs[i].wdata;
      data_wr    = vecs[i].wr;
      #1;
      if (vecs[i].chk_now) chk($sformatf("vec%0d_rd_now", i), data_rdata, vecs[i].rd_now);
      @(posedge clk); #1;
      data_wr = 1'b0;
      chk($sformatf("vec%0d_acc_err", i), acc_err, vecs[i].err);
      chk($sformatf("vec%0d_rd_next", i), data_rdata, vecs[i].rd_next);
      data_addr = 32'h0;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_err_clear", i), acc_err, 0);
    end

    // write while busy is dropped; reset mid-preload keeps committed words
    start_load(0);
    @(negedge clk);
    data_addr  = 32'h4;
    data_wdata = 32'hBAD0BAD0;
    data_wr    = 1'b1;
    @(posedge clk); #1;
    data_wr   = 1'b0;
    data_addr = 32'h0;
    chk("busy_wr_acc_err", acc_err, 1);
    send_byte(8'h0A, 0, 0); send_byte(8'h0B, 0, 0);
    send_byte(8'h0C, 0, 0); send_byte(8'h0D, 0, 0);
    send_byte(8'h77, 0, 0); send_byte(8'h88, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_ld_ready", ld_ready, 0);
    chk("midrst_ld_words", ld_words, 0);
    rd_chk("midrst_mem0", 32'h0, 32'h0A0B0C0D);
    rd_chk("midrst_mem1", 32'h4, 32'hAABB0000);
    @(negedge clk);
    rst_n = 1'b1;
    data_addr = 32'h0;

    // overflow on the 4-word instance
    start_load(1);
    for (int i = 0; i < 16; i++) send_byte(8'(i + 1), 0, 1);
    @(negedge clk);
    @(negedge clk);
    chk("ovf_busy", busy2, 0);
    chk("ovf_flag", ld_ovf2, 1);
    chk("ovf_ld_words", ld_words2, 4);
    ld_valid = 1'b1;
    ld_byte  = 8'h99;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("ovf_no_ready%0d", i), ld_ready2, 0);
    end
    ld_valid = 1'b0;
    data_addr2 = 32'h0;
    #1;
    chk("ovf_mem0", data_rdata2, 32'h01020304);
    data_addr2 = 32'hC;
    #1;
    chk("ovf_mem3", data_rdata2, 32'h0D0E0F10);
    start_load(1);
    @(negedge clk);
    chk("ovf_cleared", ld_ovf2, 0);
    chk("ovf_restart_busy", busy2, 1);
    chk("ovf_restart_words", ld_words2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Target end of the core's data-memory port. Answers the core's word reads in the same cycle and commits its writes on the clock edge.
- Also has a byte-serial loader port with a valid/ready handshake. A bench or boot module uses it to preload the data image before the core runs.
- Sits beside the core and replaces the bare data-memory model. Keeps the existing single-cycle timing: no wait states are visible to the core.

Parameters:
- ADDR_W, 8, word-address width; memory depth = 2**ADDR_W words.
- DATA_W, 32, word width in bits; fixed at 32, byte lanes assume 4 bytes per word.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- data_addr  in  32  byte address from the core.
- data_wdata  in  32  store data from the core (the core's data_out).
- data_wr  in  1  store strobe, 1 = write this cycle.
- data_rdata  out  32  load data to the core (the core's data_in); combinational.
- acc_err  out  1  registered one-cycle pulse on a misaligned or out-of-range access.
- ld_start  in  1  one-cycle pulse that begins a preload at word 0.
- ld_valid  in  1  loader byte valid.
- ld_byte  in  8  loader byte; big-endian order, MSB byte of each word first.
- ld_last  in  1  marks the final byte of the image; qualified by ld_valid.
- ld_ready  out  1  responder accepts a loader byte this cycle.
- busy  out  1  preload in progress (state != IDLE).
- ld_words  out  ADDR_W+1  number of words committed by the last or current preload.
- ld_ovf  out  1  sticky flag: image exceeded the memory depth; cleared by the next ld_start.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE.
  - ld_ready, busy, acc_err, ld_ovf = 0; ld_words = 0.
  - Internal byte_cnt = 0, shift register = 0.
  - Memory array is NOT reset; its contents are undefined after power-up.
- Core read:
  - data_rdata = mem[data_addr[ADDR_W+1:2]] combinationally, in the same cycle.
  - Returns 0 if the address is out of range (data_addr[31:ADDR_W+2] != 0).
- Core write:
  - On rising clk with data_wr=1, in range and aligned: mem[word] <= data_wdata.
  - Read-during-write to the same word: data_rdata shows the OLD value that cycle and the new value from the next cycle.
- Access error:
  - acc_err=1 for exactly the cycle after any access with data_addr[1:0] != 0, or with an out-of-range address when data_wr=1.
  - Erroneous writes are dropped.
  - Misaligned reads still return the word at data_addr[ADDR_W+1:2].
- While busy: core writes are dropped and raise acc_err; core reads are still serviced.
- FSM states: IDLE, LOAD, COMMIT.
- IDLE:
  - ld_ready=0.
  - On ld_start: ptr=0, byte_cnt=0, ld_words=0, ld_ovf=0, go to LOAD.
  - ld_start outside IDLE is ignored.
- LOAD:
  - ld_ready=1.
  - On ld_valid & ld_ready: shreg = {shreg[23:0], ld_byte}, byte_cnt++.
  - Go to COMMIT when byte_cnt reaches 4 or when ld_last is accepted.
  - On ld_last with fewer than 4 bytes: the missing low bytes are zero-padded, so the word is left-justified.
- COMMIT (exactly one cycle, ld_ready=0):
  - mem[ptr] <= shreg; ld_words++; byte_cnt=0; shreg=0.
  - If last_seen: go to IDLE.
  - Else if ptr == 2**ADDR_W-1: set ld_ovf=1 and go to IDLE. Any further bytes receive no ready.
  - Else ptr++ and go to LOAD.
- Loader throughput: 4 accepted bytes + 1 commit cycle per word, i.e. minimum 5 cycles per word.
- A loader commit and a core write never collide, because core writes are blocked while busy.
- Reset mid-preload: returns to IDLE immediately. Words already committed are kept; the partial word is lost.

Decomposition:
- Shared package mips_mem_pkg:
  - FSM state enum (IDLE, LOAD, COMMIT).
  - Constant BYTES_PER_WORD=4.
  - Function for the alignment and range check, shared with the instruction-side responder.
- Natural sub-module: dmem_loader_fsm. It holds the handshake, shift register and ptr, and outputs one write port (we, waddr, wdata) to the array muxed in the top level.

Test Plan:
- Reset, then ld_start, then 8 bytes 0x12,0x34,0x56,0x78,0x9A,0xBC,0xDE,0xF0 with ld_last on the 8th -> mem[0]=0x12345678, mem[1]=0x9ABCDEF0, ld_words=2, busy drops 1 cycle after the 2nd COMMIT.
- 6-byte image ending 0xAA,0xBB with ld_last -> mem[1]=0xAABB0000, ld_words=2.
- Core write data_addr=0x8, data_wdata=0xCAFEF00D, data_wr=1 -> data_rdata at addr 0x8 reads old value that cycle, 0xCAFEF00D from the next cycle; acc_err stays 0.
- Write to 0x6 (misaligned) and to 0x400 (out of range for ADDR_W=8) -> acc_err pulses 1 cycle each, memory unchanged; read of 0x400 returns 0.
- ADDR_W=2, 20-byte image without ld_last -> 4 words written, ld_ovf=1, ld_ready stays 0 afterwards; the next ld_start clears ld_ovf.
- Assert rst_n low after 2 bytes of word 1 -> busy=0 and ld_ready=0 immediately; mem[0] retained.
